chi_rx_req_link: RTL
====================

Name: chi_rx_req_link

Overview:
- CHI link-layer receiver for the request channel (NoC to HN). Sits directly upstream of HN_controller's rx_req port.
- Grants L-credits to the NoC and captures incoming request flits into a credit-backed FIFO.
- Presents flits to the HN controller through a valid/ready handshake.
- Guarantees that flits in flight never exceed the buffer depth.

Parameters:
- FLIT_W, 128: request flit width in bits; carries chi_package request_flit_t.
- DEPTH, 8: FIFO entries and maximum L-credits; legal range 1..15 (CHI L-credit limit).
- CNT_W, $clog2(DEPTH+1): width of counters; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- link_en  in  1  RX link active; credits are granted only while high.
- rx_flitpend  in  1  early flit indication; unused except as a sampling hint; no behavioural effect.
- rx_flitv  in  1  flit valid, one cycle per flit.
- rx_flit  in  FLIT_W  flit payload, sampled when rx_flitv=1.
- rx_lcrdv  out  1  L-credit grant, one credit per high cycle.
- out_valid  out  1  head flit available to HN controller.
- out_flit  out  FLIT_W  head flit payload.
- out_ready  in  1  HN controller accepts head flit.
- credits_out  out  CNT_W  credits granted and not yet consumed.
- occupancy  out  CNT_W  FIFO entries held.
- proto_err  out  1  sticky: flit received with credits_out==0.

Behaviour:
- Reset values (async assert, sync release): rx_lcrdv=0, out_valid=0, out_flit=0, credits_out=0, occupancy=0, proto_err=0, read and write pointers=0.
- Accept: rx_flitv=1 and credits_out>0. The flit is written at the write pointer, occupancy increments, credits_out decrements.
- Illegal flit: rx_flitv=1 with credits_out==0. The flit is dropped, no counter changes, proto_err sets and stays set until reset.
- Pop: out_valid && out_ready. The read pointer advances and occupancy decrements.
- Simultaneous accept and pop: occupancy unchanged.
- Pop when occupancy==1 with a simultaneous accept: the new flit becomes head next cycle.
- Latency: a flit accepted at edge N gives out_valid=1 with that flit from edge N+1 (one cycle). out_flit is driven straight from the head register, with no combinational path from rx_flit.
- out_valid = (occupancy != 0).
- out_flit holds its value while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two, so use explicit wrap compare.
- rx_lcrdv is registered. Next value = link_en && (occupancy_next + credits_out_next < DEPTH), where both terms are post-update values for this edge.
- credits_out increments at each edge where rx_lcrdv=1. Increment and decrement may coincide, giving net zero.
- Invariant: occupancy + credits_out <= DEPTH at all times.
- Credit pacing:
  - From empty, with link_en high from the cycle after reset release, rx_lcrdv is high for exactly DEPTH consecutive cycles, then low.
  - A pop re-enables one grant on the following edge.
- link_en low: no new grants, starting the next edge. Outstanding credits remain valid, and flits against them are still accepted.
- link_en deassert mid-burst: the already-registered rx_lcrdv pulse completes and is counted.
- Full: occupancy==DEPTH implies credits_out==0, so rx_lcrdv=0 and any further flit is an illegal flit.
- Empty: out_valid=0. out_ready is ignored and out_flit holds its last value.
- Reset mid-operation: all contents and credits are discarded immediately. No grants until the cycle after rstn release.

Optional Feature:
- Macro: CHI_RX_HWM_EN.
- Defined: adds output port hwm [CNT_W], reset 0. hwm updates to occupancy_next whenever occupancy_next > hwm, giving peak FIFO occupancy since reset. It is never cleared except by rstn.
- Undefined: no hwm port and no associated logic. All other behaviour is identical.

Test Plan:
- Credit ramp: DEPTH=8, link_en=1 from reset release, no flits -> rx_lcrdv high for exactly 8 cycles, credits_out=8, then rx_lcrdv stays 0.
- Single flit: after ramp, send rx_flit=0xA5 at edge N with out_ready=1 -> out_valid=1 and out_flit=0xA5 at N+1. Pop at N+1. rx_lcrdv=1 at N+2. credits_out returns to 8.
- Fill and backpressure: out_ready=0, send 8 flits 0x01..0x08 -> occupancy=8, credits_out=0, rx_lcrdv=0. Release out_ready -> flits 0x01..0x08 delivered in order, one per cycle. Credits regranted one per pop.
- Protocol error: with credits_out=0, drive rx_flitv with 0xFF -> flit dropped, occupancy unchanged, proto_err=1 until rstn asserted.
- Simultaneous push/pop with wrap: DEPTH=5, stream 20 flits with out_ready=1 -> occupancy stays <=1, pointers wrap 4 times, output order matches input, invariant holds every cycle.
- link_en and reset: drop link_en after 3 grants -> credits_out stops at 3, and 3 flits are still accepted. Assert rstn mid-stream -> all outputs return to reset values asynchronously. With CHI_RX_HWM_EN, hwm reads 3 before reset and 0 after.

Source files
------------

// File: rtl/chi_rx_req_link_if.sv
// Handshake bundle between the CHI request-channel link and the HN controller.
// The slave modport is the link receiver's view; the master modport is the view of whoever drives it.
interface chi_rx_req_link_if #(
   parameter int FLIT_W = 128
);
   // NoC side: rx_flitv marks one flit per cycle and is legal only against a granted
   // L-credit (rx_lcrdv pulse). HN side: a head flit transfers on any rising edge where
   // out_valid && out_ready. out_valid never depends on out_ready, and out_flit is
   // stable while out_valid && !out_ready.
   logic              rx_flitpend;
   logic              rx_flitv;
   logic [FLIT_W-1:0] rx_flit;
   logic              rx_lcrdv;
   logic              out_valid;
   logic [FLIT_W-1:0] out_flit;
   logic              out_ready;

   modport slave (
      input  rx_flitpend, rx_flitv, rx_flit, out_ready,
      output rx_lcrdv, out_valid, out_flit
   );

   modport master (
      output rx_flitpend, rx_flitv, rx_flit, out_ready,
      input  rx_lcrdv, out_valid, out_flit
   );
endinterface

// File: rtl/chi_rx_req_link.sv
// CHI request-channel link receiver: grants L-credits to the NoC and buffers flits for the HN.
// Build macro CHI_RX_HWM_EN adds the hwm output (peak occupancy since reset).
module chi_rx_req_link #(
   parameter  int FLIT_W = 128,
   parameter  int DEPTH  = 8,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             link_en,
   chi_rx_req_link_if.slave lnk,
   output logic [CNT_W-1:0] credits_out,
   output logic [CNT_W-1:0] occupancy,
`ifdef CHI_RX_HWM_EN
   output logic [CNT_W-1:0] hwm,
`endif
   output logic             proto_err
);
   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic [CNT_W-1:0]  cred_q, cred_d;
   logic              lcrdv_q, lcrdv_d;
   logic              err_q, err_d;
   logic [FLIT_W-1:0] head_q, head_d;
   logic              accept;
   logic              pop;
   logic              unused_flitpend;

   assign unused_flitpend = lnk.rx_flitpend;

   always_comb begin
      accept   = lnk.rx_flitv && (cred_q != '0);
      pop      = (occ_q != '0) && lnk.out_ready;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
      occ_d   = occ_q + CNT_W'(accept) - CNT_W'(pop);
      cred_d  = cred_q + CNT_W'(lcrdv_q) - CNT_W'(accept);
      lcrdv_d = link_en && (({1'b0, occ_d} + {1'b0, cred_d}) < DEPTH_W);
      err_d   = err_q || (lnk.rx_flitv && (cred_q == '0));
      // The incoming flit lands on the new head slot only when it is the sole entry next cycle,
      // so it bypasses the array into the head register; otherwise the head comes from storage.
      head_d = head_q;
      if (occ_d != '0) head_d = (accept && (wr_ptr_q == rd_ptr_d)) ? lnk.rx_flit : mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         cred_q   <= '0;
         lcrdv_q  <= 1'b0;
         err_q    <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cred_q   <= cred_d;
         lcrdv_q  <= lcrdv_d;
         err_q    <= err_d;
         head_q   <= head_d;
      end
   end

   // Storage is not reset: after reset every slot is empty and is written before it is read.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= lnk.rx_flit;
   end

`ifdef CHI_RX_HWM_EN
   logic [CNT_W-1:0] hwm_q, hwm_d;

   always_comb begin
      hwm_d = (occ_d > hwm_q) ? occ_d : hwm_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) hwm_q <= '0;
      else       hwm_q <= hwm_d;
   end

   assign hwm = hwm_q;
`endif

   assign lnk.rx_lcrdv  = lcrdv_q;
   assign lnk.out_valid = (occ_q != '0);
   assign lnk.out_flit  = head_q;
   assign credits_out   = cred_q;
   assign occupancy     = occ_q;
   assign proto_err     = err_q;
endmodule
